// File: rtl/pipo_pkg.sv
// Shared types, defaults and helpers for the serial/parallel register stages.
package pipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  // Reverse the low 'width' bits of value; bits above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        result[5'(int'(width) - 1 - i)] = value[5'(i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register and bit counter; flags the cycle that completes a word.
module sipo_shift_core
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;

  // Bits are always stored first-bit-at-top; LSB-first order is obtained by reversing the
  // completed word, which gives the same result as shifting in from the top.
  assign shift_next = {shift_reg[WIDTH-2:0], sin};
  assign word       = MSB_FIRST ? shift_next : WIDTH'(bit_reverse(32'(shift_next), WIDTH));
  assign word_done  = sin_valid && (bit_cnt == LAST_BIT);
  assign busy       = (bit_cnt != '0);

  // Shift one qualified bit per clock; counter wraps on the last bit of a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sin_valid) begin
      shift_reg <= shift_next;
      bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word valid/ready output holding register.
module sipo_deserializer
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       word_cnt
);

  out_state_t       state;
  out_state_t       state_next;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             handshake;
  logic             load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .sin      (sin),
    .sin_valid(sin_valid),
    .word     (word),
    .word_done(word_done),
    .busy     (busy)
  );

  assign out_valid = (state == OUT_FULL);
  assign handshake = out_valid && out_ready;
  // A completed word fits if the holder is empty or is being emptied at this same edge.
  assign load      = word_done && (!out_valid || out_ready);
  assign drop      = word_done && out_valid && !out_ready;

  // Output-side next state: fill on completion, empty on a handshake with no new word.
  always_comb begin
    state_next = state;
    unique case (state)
      OUT_EMPTY: if (word_done) state_next = OUT_FULL;
      OUT_FULL:  if (handshake && !word_done) state_next = OUT_EMPTY;
    endcase
  end

  // Output register, sticky overrun flag and loaded-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OUT_EMPTY;
      out_data <= '0;
      overrun  <= 1'b0;
      word_cnt <= 8'd0;
    end else if (clr) begin
      state    <= OUT_EMPTY;
      out_data <= '0;
      overrun  <= 1'b0;
      word_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if (load) begin
        out_data <= word;
        word_cnt <= word_cnt + 8'd1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share stimulus and are
// compared against a queue-based reference model.
module tb_sipo_deserializer;
  import pipo_pkg::*;

  localparam int W = 4;

  logic clk, rst, clr, sin, sin_valid, out_ready;
  logic [W-1:0] dm_data, dl_data;
  logic dm_valid, dm_busy, dm_ovr, dl_valid, dl_busy, dl_ovr;
  logic [7:0] dm_cnt, dl_cnt;

  // Reference model state
  logic [W-1:0] e_dm, e_dl;
  logic         e_vld, e_ovr;
  logic [7:0]   e_cnt;
  int           bits[$];

  int vectors = 0;
  int miscompares = 0;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .out_data(dm_data), .out_valid(dm_valid), .out_ready(out_ready),
    .busy(dm_busy), .overrun(dm_ovr), .word_cnt(dm_cnt)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .out_data(dl_data), .out_valid(dl_valid), .out_ready(out_ready),
    .busy(dl_busy), .overrun(dl_ovr), .word_cnt(dl_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    e_dm = '0; e_dl = '0; e_vld = 1'b0; e_ovr = 1'b0; e_cnt = 8'd0;
    bits.delete();
  endtask

  // One posedge of the reference: collect bits, form a word every W bits, apply the
  // holding-register rules.
  task automatic model_edge();
    int acc;
    logic [31:0] rev;
    logic done;
    logic [W-1:0] wm, wl;
    done = 1'b0; wm = '0; wl = '0;
    if (clr) begin
      model_reset();
    end else begin
      if (sin_valid) begin
        bits.push_back(int'(sin));
        if (bits.size() == W) begin
          acc = 0;
          foreach (bits[i]) acc = acc * 2 + bits[i];
          wm = acc[W-1:0];
          rev = bit_reverse(32'(acc), W);
          wl = rev[W-1:0];
          bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!e_vld || out_ready) begin
          e_dm = wm; e_dl = wl; e_vld = 1'b1; e_cnt = e_cnt + 8'd1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (e_vld && out_ready) begin
        e_vld = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic b, input logic rdy, input logic c);
    sin_valid = v; sin = b; out_ready = rdy; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_bits(input logic [7:0] pattern, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, pattern[i], rdy, 1'b0);
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt, dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt}
        !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h/%b%b%b/%h want all zero", dm_data, dm_valid, dm_busy,
               dm_ovr, dm_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_msb_first();
    do_clear();
    send_bits(8'b101, 3, 1'b1);
    vectors++;
    if ({dm_valid, dm_busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL msb_before_last got valid=%b busy=%b want valid=0 busy=1", dm_valid, dm_busy);
    end
    send_bits(8'b1, 1, 1'b1);
    vectors++;
    if ({dm_data, dm_valid, dm_busy, dm_cnt} !== {4'b1011, 1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL msb_word got data=%b v=%b busy=%b cnt=%0d want 1011 1 0 1", dm_data,
               dm_valid, dm_busy, dm_cnt);
    end
  endtask

  task automatic test_lsb_first();
    do_clear();
    send_bits(8'b1011, 4, 1'b1);
    vectors++;
    if ({dl_data, dl_valid, dl_cnt} !== {4'b1101, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL lsb_word got data=%b v=%b cnt=%0d want 1101 1 1", dl_data, dl_valid, dl_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    send_bits(8'b1011, 4, 1'b0);
    send_bits(8'b011, 3, 1'b0);
    vectors++;
    if ({dm_data, dm_valid} !== {4'b1011, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first got data=%b v=%b want 1011 1", dm_data, dm_valid);
    end
    // Last bit arrives together with the handshake of the first word.
    send_bits(8'b0, 1, 1'b1);
    vectors++;
    if ({dm_data, dm_valid, dm_ovr, dm_cnt} !== {4'b0110, 1'b1, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL b2b_reload got data=%b v=%b ovr=%b cnt=%0d want 0110 1 0 2", dm_data,
               dm_valid, dm_ovr, dm_cnt);
    end
  endtask

  task automatic test_overrun();
    do_clear();
    send_bits(8'b1011_0110, 8, 1'b0);
    vectors++;
    if ({dm_data, dm_valid, dm_ovr, dm_cnt} !== {4'b1011, 1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL overrun_drop got data=%b v=%b ovr=%b cnt=%0d want 1011 1 1 1", dm_data,
               dm_valid, dm_ovr, dm_cnt);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({dm_data, dm_valid, dm_ovr} !== {4'b1011, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_sticky got data=%b v=%b ovr=%b want 1011 0 1", dm_data, dm_valid,
               dm_ovr);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    send_bits(8'b1011, 4, 1'b0);
    send_bits(8'b11, 2, 1'b0);
    vectors++;
    if ({dm_valid, dm_busy, dm_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL pre_reset got v=%b busy=%b cnt=%0d want 1 1 1", dm_valid, dm_busy, dm_cnt);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset got data=%b v=%b busy=%b ovr=%b cnt=%0d want all zero",
               dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt);
    end
    model_reset();
    #2 rst = 1'b0;
    send_bits(8'b0110, 4, 1'b1);
    vectors++;
    if ({dm_data, dm_valid, dm_cnt} !== {4'b0110, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL post_reset_word got data=%b v=%b cnt=%0d want 0110 1 1", dm_data, dm_valid,
               dm_cnt);
    end
  endtask

  task automatic test_clr();
    do_clear();
    send_bits(8'b1011_0110, 8, 1'b0);
    send_bits(8'b1, 1, 1'b0);
    // clr together with a qualified bit and a pending handshake
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt} !== 15'd0) begin
      miscompares++;
      $display("FAIL clr_priority got data=%b v=%b busy=%b ovr=%b cnt=%0d want all zero",
               dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt);
    end
    send_bits(8'b101, 3, 1'b1);
    vectors++;
    if (dm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_bit_dropped got v=%b want 0", dm_valid);
    end
    send_bits(8'b1, 1, 1'b1);
    vectors++;
    if ({dm_data, dm_valid} !== {4'b1011, 1'b1}) begin
      miscompares++;
      $display("FAIL clr_next_word got data=%b v=%b want 1011 1", dm_data, dm_valid);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] pat;
    pat = 4'b1011;
    do_clear();
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, pat[i], 1'b1, 1'b0);
      if (i != 0) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({dm_busy, dm_valid} !== 2'b10) begin
          miscompares++;
          $display("FAIL gap_hold got busy=%b v=%b want 1 0", dm_busy, dm_valid);
        end
      end
    end
    vectors++;
    if ({dm_data, dl_data, dm_valid, dm_cnt} !== {4'b1011, 4'b1101, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL gap_word got msb=%b lsb=%b v=%b cnt=%0d want 1011 1101 1 1", dm_data,
               dl_data, dm_valid, dm_cnt);
    end
  endtask

  task automatic test_count_wrap();
    do_clear();
    for (int k = 0; k < 256; k++) begin
      for (int b = 0; b < W; b++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (k == 254) begin
        vectors++;
        if (dm_cnt !== 8'd255) begin
          miscompares++;
          $display("FAIL cnt_255 got %0d want 255", dm_cnt);
        end
      end
    end
    vectors++;
    if ({dm_cnt, dm_valid, dm_data} !== {8'd0, 1'b1, e_dm}) begin
      miscompares++;
      $display("FAIL cnt_wrap got cnt=%0d v=%b data=%b want 0 1 %b", dm_cnt, dm_valid, dm_data,
               e_dm);
    end
  endtask

  task automatic test_random();
    logic [29:0] got, exp;
    logic busy_e;
    do_clear();
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
      busy_e = (bits.size() != 0);
      got = {dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt, dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt};
      exp = {e_dm, e_vld, busy_e, e_ovr, e_cnt, e_dl, e_vld, busy_e, e_ovr, e_cnt};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_cycle_%0d got %h want %h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    test_clr();
    test_gaps();
    test_count_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
